// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch mode controller and the display driver.
package stopwatch_pkg;

    localparam int CNT_W_DEF   = 6;
    localparam int MAX_SEC_DEF = 59;
    localparam int MAX_MIN_DEF = 59;

    localparam int ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
    localparam logic [ST_W-1:0] ST_PAUSE  = 2'd1;
    localparam logic [ST_W-1:0] ST_ADJUST = 2'd2;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/stopwatch_ctrl_mod_counter.sv
// Modulo-(MAX+1) up-counter with synchronous clear; clear beats increment.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign wrap = inc && (value == MAX_V);

    // Out-of-range values (only reachable by upset) fold back to 0 on the next increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value >= MAX_V) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM and mm:ss time-base.
//   state     | meaning
//   ST_RUN    | counting on tick_1hz
//   ST_PAUSE  | time frozen
//   ST_ADJUST | selected field steps on tick_2hz, display blinks
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int MAX_MIN = MAX_MIN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             pause_pulse,
    input  logic             clear_pulse,
    input  logic             adj,
    input  logic             sel,
    output logic [CNT_W-1:0] min_out,
    output logic [CNT_W-1:0] sec_out,
    output logic             running,
    output logic             adj_active,
    output logic             tick_sel,
    output logic             blink_phase
);

    state_t state;
    state_t state_nxt;
    logic   paused_save;
    logic   save_nxt;
    logic   blink_nxt;
    logic   sec_inc;
    logic   min_inc;
    logic   sec_wrap;
    logic   min_wrap;

    always_comb begin
        state_nxt = state;
        save_nxt  = paused_save;
        case (state)
            ST_RUN: begin
                if (adj) begin
                    state_nxt = ST_ADJUST;
                    save_nxt  = 1'b0;
                end else if (pause_pulse) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (adj) begin
                    state_nxt = ST_ADJUST;
                    save_nxt  = 1'b1;
                end else if (pause_pulse) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (pause_pulse) begin
                    save_nxt = ~paused_save;
                end
                if (!adj) begin
                    state_nxt = paused_save ? ST_PAUSE : ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Blink is cleared on the same edge that leaves ADJUST.
    assign blink_nxt = (state == ST_ADJUST && adj) ? (blink_phase ^ tick_2hz) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            paused_save <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            state       <= state_nxt;
            paused_save <= save_nxt;
            blink_phase <= blink_nxt;
        end
    end

    // Increments follow the pre-edge state; adjust steps never carry.
    assign sec_inc = (state == ST_RUN && tick_1hz)
                   || (state == ST_ADJUST && tick_2hz && sel == SEL_SEC);
    assign min_inc = (state == ST_RUN && tick_1hz && sec_wrap)
                   || (state == ST_ADJUST && tick_2hz && sel == SEL_MIN);

    mod_counter #(.W(CNT_W), .MAX(MAX_SEC)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (clear_pulse),
        .value (sec_out),
        .wrap  (sec_wrap)
    );

    mod_counter #(.W(CNT_W), .MAX(MAX_MIN)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (clear_pulse),
        .value (min_out),
        .wrap  (min_wrap)
    );

    assign running    = (state == ST_RUN);
    assign adj_active = (state == ST_ADJUST);
    assign tick_sel   = (state == ST_ADJUST);

endmodule
